serial_subtractor32: RTL and testbench

- Multi-cycle 32-bit subtractor: computes D = A − B − Bin, one 4-bit digit per clock, LSB digit first.
- The borrow ripples between cycles through a borrow register.
- Counterpart of the team's nibble-chained ripple adder.
- Used in area-constrained datapaths where one shared 4-bit subtract cell is cheaper than a full 32-bit chain; valid/ready on both sides.

---
 rtl/serial_subtractor32_pkg.sv | 15 +
 rtl/serial_subtractor32_fullsubtractor4.sv | 19 +
 rtl/serial_subtractor32.sv | 139 +++++++++++++
 tb/tb_serial_subtractor32.sv | 209 ++++++++++++++++++++
 4 files changed

// File: rtl/serial_subtractor32_pkg.sv
// rtl/serial_subtractor32_pkg.sv - shared constants and state type for the digit-serial subtractor
package serial_subtractor32_pkg;

    localparam int WIDTH_DEF = 32;
    localparam int DIGIT_DEF = 4;
    localparam int STEPS     = WIDTH_DEF / DIGIT_DEF;
    localparam int CNT_W     = $clog2(STEPS);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

endpackage

// File: rtl/serial_subtractor32_fullsubtractor4.sv
// rtl/serial_subtractor32_fullsubtractor4.sv - combinational 4-bit a - b - borrow cell
module fullsubtractor4 (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    input  logic       bin_i,
    output logic [3:0] d_o,
    output logic       bout_o
);

    logic [4:0] diff;

    // A 5-bit difference goes negative exactly when a < b + bin; bit 4 is then the borrow.
    always_comb begin
        diff   = {1'b0, a_i} - {1'b0, b_i} - {4'd0, bin_i};
        d_o    = diff[3:0];
        bout_o = diff[4];
    end

endmodule

// File: rtl/serial_subtractor32.sv
// rtl/serial_subtractor32.sv - digit-serial A - B - Bin, one digit per clock; SUBTRACTOR_FLAGS_EN adds Z/V flags
module serial_subtractor32
    import serial_subtractor32_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DIGIT = DIGIT_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    input  logic             Bin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] D,
`ifdef SUBTRACTOR_FLAGS_EN
    output logic             Z,
    output logic             V,
`endif
    output logic             Bout
);

    localparam int STEPS_L = WIDTH / DIGIT;
    localparam int CW      = (STEPS_L > 1) ? $clog2(STEPS_L) : 1;
    localparam logic [CW-1:0] LAST = CW'(STEPS_L - 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d;
    logic [WIDTH-1:0] b_q, b_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             brw_q, brw_d;
    logic             bout_q, bout_d;
    logic [DIGIT-1:0] dig_d;
    logic             dig_b;
`ifdef SUBTRACTOR_FLAGS_EN
    logic             z_q, z_d;
    logic             v_q, v_d;
`endif

    // One shared cell, fed the current digit of each operand and the rippled borrow.
    fullsubtractor4 u_cell (
        .a_i    (a_q[cnt_q*DIGIT +: DIGIT]),
        .b_i    (b_q[cnt_q*DIGIT +: DIGIT]),
        .bin_i  (brw_q),
        .d_o    (dig_d),
        .bout_o (dig_b)
    );

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            d_q     <= '0;
            cnt_q   <= '0;
            brw_q   <= 1'b0;
            bout_q  <= 1'b0;
`ifdef SUBTRACTOR_FLAGS_EN
            z_q     <= 1'b0;
            v_q     <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            d_q     <= d_d;
            cnt_q   <= cnt_d;
            brw_q   <= brw_d;
            bout_q  <= bout_d;
`ifdef SUBTRACTOR_FLAGS_EN
            z_q     <= z_d;
            v_q     <= v_d;
`endif
        end
    end

    // Next-state and handshake decode: capture in IDLE, one digit per RUN cycle, hold in DONE.
    always_comb begin
        state_d   = state_q;
        a_d       = a_q;
        b_d       = b_q;
        d_d       = d_q;
        cnt_d     = cnt_q;
        brw_d     = brw_q;
        bout_d    = bout_q;
        in_ready  = 1'b0;
        out_valid = 1'b0;
`ifdef SUBTRACTOR_FLAGS_EN
        z_d       = z_q;
        v_d       = v_q;
`endif
        case (state_q)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    a_d     = A;
                    b_d     = B;
                    brw_d   = Bin;
                    cnt_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                d_d[cnt_q*DIGIT +: DIGIT] = dig_d;
                brw_d = dig_b;
                if (cnt_q == LAST) begin
                    bout_d  = dig_b;
                    state_d = DONE;
`ifdef SUBTRACTOR_FLAGS_EN
                    // Flags see the complete result including the digit written this cycle.
                    z_d = (d_d == '0);
                    v_d = (a_q[WIDTH-1] != b_q[WIDTH-1]) && (d_d[WIDTH-1] != a_q[WIDTH-1]);
`endif
                end else begin
                    cnt_d = cnt_q + CW'(1);
                end
            end
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign D    = d_q;
    assign Bout = bout_q;
`ifdef SUBTRACTOR_FLAGS_EN
    assign Z    = z_q;
    assign V    = v_q;
`endif

endmodule

// File: tb/tb_serial_subtractor32.sv
// tb/tb_serial_subtractor32.sv - directed self-checking bench for serial_subtractor32
module tb_serial_subtractor32;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] A = '0;
    logic [31:0] B = '0;
    logic        Bin = 1'b0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [31:0] D;
    logic        Bout;
`ifdef SUBTRACTOR_FLAGS_EN
    logic        Z;
    logic        V;
`endif

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    serial_subtractor32 dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .A         (A),
        .B         (B),
        .Bin       (Bin),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .D         (D),
`ifdef SUBTRACTOR_FLAGS_EN
        .Z         (Z),
        .V         (V),
`endif
        .Bout      (Bout)
    );

    // Wait (bounded) for in_ready, present operands, let them be accepted, then drop in_valid.
    task automatic accept(input logic [31:0] a, input logic [31:0] b, input logic bin, input string nm);
        int guard = 0;
        @(negedge clk);
        while (!in_ready && guard < 30) begin
            @(negedge clk);
            guard++;
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL %s accept: in_ready=%b required 1", nm, in_ready);
        end
        A = a; B = b; Bin = bin; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
    endtask

    // Count cycles from the accept edge to out_valid and check latency and result; leaves DUT in DONE.
    task automatic wait_check(input logic [31:0] ed, input logic eb, input string nm);
        int cyc = 0;
        while (out_valid !== 1'b1 && cyc < 20) begin
            @(posedge clk);
            #1 cyc++;
        end
        checks++;
        if (cyc !== 8) begin
            errors++;
            $display("FAIL %s latency: got %0d cycles required 8", nm, cyc);
        end
        checks++;
        if (D !== ed) begin
            errors++;
            $display("FAIL %s D: got %h required %h", nm, D, ed);
        end
        checks++;
        if (Bout !== eb) begin
            errors++;
            $display("FAIL %s Bout: got %b required %b", nm, Bout, eb);
        end
    endtask

    // Drain the result and confirm the block is back in IDLE with D retained.
    task automatic drain(input logic [31:0] ed, input string nm);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || D !== ed) begin
            errors++;
            $display("FAIL %s drain: out_valid=%b in_ready=%b D=%h required 0 1 %h", nm, out_valid, in_ready, D, ed);
        end
    endtask

    task automatic test_reset;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0 || D !== 32'h0 || Bout !== 1'b0) begin
            errors++;
            $display("FAIL reset: in_ready=%b out_valid=%b D=%h Bout=%b required 1 0 0 0", in_ready, out_valid, D, Bout);
        end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_basic;
        accept(32'h0000_0005, 32'h0000_0003, 1'b0, "basic");
        wait_check(32'h0000_0002, 1'b0, "basic");
        drain(32'h0000_0002, "basic");
    endtask

    task automatic test_ripple;
        accept(32'h0000_0000, 32'h0000_0001, 1'b0, "ripple");
        wait_check(32'hFFFF_FFFF, 1'b1, "ripple");
        drain(32'hFFFF_FFFF, "ripple");
    endtask

    task automatic test_borrow_in;
        accept(32'h1000_0000, 32'h0000_0001, 1'b1, "bin1");
        wait_check(32'h0FFF_FFFE, 1'b0, "bin1");
        drain(32'h0FFF_FFFE, "bin1");
        accept(32'h1234_5678, 32'hFFFF_FFFF, 1'b1, "bin_allones");
        wait_check(32'h1234_5678, 1'b1, "bin_allones");
        drain(32'h1234_5678, "bin_allones");
    endtask

    task automatic test_back_to_back;
        accept(32'hDEAD_BEEF, 32'h1111_1111, 1'b0, "bp_first");
        wait_check(32'hCD9C_ADDE, 1'b0, "bp_first");
        @(negedge clk);
        A = 32'h0000_00FF; B = 32'h0000_0100; Bin = 1'b0; in_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || D !== 32'hCD9C_ADDE || Bout !== 1'b0) begin
                errors++;
                $display("FAIL backpressure cycle %0d: out_valid=%b in_ready=%b D=%h Bout=%b required 1 0 cd9caddd+1 0", i, out_valid, in_ready, D, Bout);
            end
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL backpressure release: in_ready=%b out_valid=%b required 1 0", in_ready, out_valid);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        wait_check(32'hFFFF_FFFF, 1'b1, "bp_second");
        drain(32'hFFFF_FFFF, "bp_second");
    endtask

    task automatic test_reset_mid_run;
        accept(32'h0F0F_0F0F, 32'h0101_0101, 1'b0, "abort");
        repeat (3) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || D !== 32'h0 || Bout !== 1'b0) begin
            errors++;
            $display("FAIL abort: out_valid=%b in_ready=%b D=%h Bout=%b required 0 1 0 0", out_valid, in_ready, D, Bout);
        end
        @(negedge clk);
        rst = 1'b0;
        accept(32'hFFFF_FFFF, 32'h0000_000F, 1'b0, "after_abort");
        wait_check(32'hFFFF_FFF0, 1'b0, "after_abort");
        drain(32'hFFFF_FFF0, "after_abort");
    endtask

`ifdef SUBTRACTOR_FLAGS_EN
    task automatic test_flags;
        accept(32'h8000_0000, 32'h0000_0001, 1'b0, "flags_ovf");
        wait_check(32'h7FFF_FFFF, 1'b0, "flags_ovf");
        checks++;
        if (V !== 1'b1 || Z !== 1'b0) begin
            errors++;
            $display("FAIL flags_ovf: V=%b Z=%b required 1 0", V, Z);
        end
        drain(32'h7FFF_FFFF, "flags_ovf");
        accept(32'h1234_5678, 32'h1234_5678, 1'b0, "flags_zero");
        wait_check(32'h0000_0000, 1'b0, "flags_zero");
        checks++;
        if (V !== 1'b0 || Z !== 1'b1) begin
            errors++;
            $display("FAIL flags_zero: V=%b Z=%b required 0 1", V, Z);
        end
        drain(32'h0000_0000, "flags_zero");
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_ripple();
        test_borrow_in();
        test_back_to_back();
        test_reset_mid_run();
`ifdef SUBTRACTOR_FLAGS_EN
        test_flags();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
